// File: rtl/bufcap.sv
// Multi-channel capture buffer: one-shot or triggered-circular capture with
// optional decimation, and a fixed two-cycle random-access read port.
module bufcap #(
  parameter  int DWW   = 8,
  parameter  int DWR   = 32,
  parameter  int AWW   = 8,
  parameter  int NCH   = 2,
  parameter  int DECW  = 8,
  parameter  int SIM   = 0,
  localparam int RATIO = DWR / DWW,
  localparam int LW    = $clog2(RATIO),
  localparam int AWR   = AWW - LW,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 cfg_mode,
  input  logic [AWW-1:0]       cfg_post,
  input  logic [DECW-1:0]      cfg_dec,
  input  logic                 trig,
  input  logic                 wen,
  input  logic [NCH*DWW-1:0]   wdata,
  input  logic                 ren,
  input  logic [CHW+AWR-1:0]   raddr,
  output logic [DWR-1:0]       rdata,
  output logic                 rdv,
  output logic                 busy,
  output logic                 done,
  output logic [AWW:0]         wcount,
  output logic [AWW-1:0]       start_addr
);

  typedef enum logic [1:0] {IDLE, FILL, POST, DONE} state_t;

  localparam logic [AWW:0] FULL = {1'b1, {AWW{1'b0}}};

  state_t          state, state_nx;
  logic            mode_q;
  logic [AWW-1:0]  post_q;
  logic [DECW-1:0] dec_q;
  logic [AWW-1:0]  waddr, waddr_nx;
  logic [AWW:0]    wcount_nx;
  logic [DECW-1:0] dec_cnt, dec_cnt_nx;
  logic [AWW-1:0]  post_cnt, post_cnt_nx;
  logic [AWW-1:0]  start_nx;
  logic            active, accept;

  // arm overrides everything else in its cycle, including a coincident wen/trig.
  always_comb begin
    active      = (state == FILL) || (state == POST);
    accept      = !arm && active && wen && (dec_cnt == '0);
    state_nx    = state;
    waddr_nx    = waddr;
    wcount_nx   = wcount;
    dec_cnt_nx  = dec_cnt;
    post_cnt_nx = post_cnt;
    start_nx    = start_addr;
    if (arm) begin
      state_nx   = FILL;
      waddr_nx   = '0;
      wcount_nx  = '0;
      dec_cnt_nx = '0;
      start_nx   = '0;
    end else if (active) begin
      if (wen) begin
        if (dec_cnt == '0) begin
          waddr_nx   = waddr + 1'b1;
          dec_cnt_nx = dec_q;
          if (wcount != FULL) wcount_nx = wcount + 1'b1;
        end else begin
          dec_cnt_nx = dec_cnt - 1'b1;
        end
      end
      case (state)
        FILL: begin
          if (!mode_q) begin
            if (accept && (wcount == FULL - 1'b1)) state_nx = DONE;
          end else if (trig) begin
            post_cnt_nx = post_q;
            state_nx    = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (accept) begin
            post_cnt_nx = post_cnt - 1'b1;
            if (post_cnt == AWW'(1)) state_nx = DONE;
          end
        end
        default: ;
      endcase
      // Oldest retained sample sits at the next write address once the buffer has wrapped.
      if (mode_q && (state_nx == DONE)) start_nx = (wcount_nx == FULL) ? waddr_nx : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waddr      <= '0;
      wcount     <= '0;
      dec_cnt    <= '0;
      post_cnt   <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_q     <= 1'b0;
      post_q     <= '0;
      dec_q      <= '0;
    end else begin
      state      <= state_nx;
      waddr      <= waddr_nx;
      wcount     <= wcount_nx;
      dec_cnt    <= dec_cnt_nx;
      post_cnt   <= post_cnt_nx;
      start_addr <= start_nx;
      busy       <= (state_nx == FILL) || (state_nx == POST);
      done       <= (state_nx == DONE);
      if (arm) begin
        mode_q <= cfg_mode;
        post_q <= cfg_post;
        dec_q  <= cfg_dec;
      end
    end
  end

  // Read handshake: ren is a single-cycle request with no backpressure; every
  // request returns exactly one rdv pulse with rdata two clocks later.
  logic [CHW-1:0] rch;
  logic [AWR-1:0] rword;
  logic           ch_ok;
  logic           rd1_v, rd1_ok;
  logic [DWR-1:0] rd1_word;

  assign rch   = raddr[CHW+AWR-1:AWR];
  assign rword = raddr[AWR-1:0];
  assign ch_ok = int'(rch) < NCH;

  if (SIM == 0) begin : g_word_mem
    localparam int LWS = (LW > 0) ? LW : 1;
    logic [DWR-1:0] mem [NCH][2**AWR];
    logic [AWR-1:0] wword;
    logic [LWS-1:0] wlane;

    assign wword = waddr[AWW-1:LW];
    if (LW == 0) begin : g_no_lane
      assign wlane = '0;
    end else begin : g_lane
      assign wlane = waddr[LWS-1:0];
    end

    // Word-wide storage with per-sample lane writes keeps a single read port.
    always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++)
        if (accept) mem[c][wword][wlane*DWW +: DWW] <= wdata[c*DWW +: DWW];
      if (ren && ch_ok) rd1_word <= mem[rch][rword];
    end
  end else begin : g_sample_mem
    logic [DWW-1:0] smem [NCH][2**AWW];

    always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++)
        if (accept) smem[c][waddr] <= wdata[c*DWW +: DWW];
      if (ren && ch_ok)
        for (int i = 0; i < RATIO; i++)
          rd1_word[i*DWW +: DWW] <= smem[rch][(AWW'(rword) << LW) | AWW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_v  <= 1'b0;
      rd1_ok <= 1'b0;
      rdv    <= 1'b0;
      rdata  <= '0;
    end else begin
      rd1_v  <= ren;
      rd1_ok <= ch_ok;
      rdv    <= rd1_v;
      if (rd1_v) rdata <= rd1_ok ? rd1_word : '0;
    end
  end

endmodule

// File: tb/tb_bufcap.sv
// Directed bench for bufcap: capture scenarios followed by table-driven reads
// checked through an expected-data queue with a two-cycle latency model.
module tb_bufcap;
  localparam int DWW  = 8;
  localparam int DWR  = 32;
  localparam int AWW  = 4;
  localparam int NCH  = 2;
  localparam int DECW = 8;
  localparam int NVEC = 17;

  logic                clk = 1'b0;
  logic                reset, arm, cfg_mode, trig, wen, ren;
  logic [AWW-1:0]      cfg_post;
  logic [DECW-1:0]     cfg_dec;
  logic [NCH*DWW-1:0]  wdata;
  logic [2:0]          raddr;
  logic [DWR-1:0]      rdata;
  logic                rdv, busy, done;
  logic [AWW:0]        wcount;
  logic [AWW-1:0]      start_addr;

  bufcap #(.DWW(DWW), .DWR(DWR), .AWW(AWW), .NCH(NCH), .DECW(DECW), .SIM(0)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cfg_mode(cfg_mode), .cfg_post(cfg_post),
    .cfg_dec(cfg_dec), .trig(trig), .wen(wen), .wdata(wdata), .ren(ren), .raddr(raddr),
    .rdata(rdata), .rdv(rdv), .busy(busy), .done(done), .wcount(wcount),
    .start_addr(start_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          scen;
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t        vecs [NVEC];
  logic [DWR-1:0] exp_q [$];
  bit             care_q [$];
  string          nm_q [$];
  int             n_checks = 0;
  int             n_fail   = 0;
  bit             lat1 = 1'b0;
  bit             lat2 = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: one clock, then rdv must equal the request issued two edges ago
  task automatic tick();
    logic [DWR-1:0] e;
    bit             c;
    string          nm;
    @(posedge clk);
    lat2 = lat1;
    lat1 = ren && !reset;
    #1;
    if (!reset) begin
      chk("rdv_latency", {31'b0, rdv}, {31'b0, lat2});
      if (lat2 && exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        c  = care_q.pop_front();
        nm = nm_q.pop_front();
        if (c) chk(nm, rdata, e);
      end
    end
  endtask

  // driver tasks
  task automatic sample(int n, bit t);
    wen   = 1'b1;
    trig  = t;
    wdata = {8'(8'h80 + n), 8'(n)};
    tick();
    wen  = 1'b0;
    trig = 1'b0;
  endtask

  task automatic do_arm(bit mode, int post, int dec);
    arm      = 1'b1;
    cfg_mode = mode;
    cfg_post = post[AWW-1:0];
    cfg_dec  = dec[DECW-1:0];
    tick();
    arm = 1'b0;
  endtask

  task automatic run_reads(int scen);
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].scen == scen) begin
        ren   = 1'b1;
        raddr = vecs[i].addr;
        exp_q.push_back(vecs[i].exp);
        care_q.push_back(1'b1);
        nm_q.push_back($sformatf("rdata_s%0d_a%0d", scen, vecs[i].addr));
        tick();
      end
    end
    ren = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_status(string tag, bit e_busy, bit e_done, int e_wcount, int e_start);
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, e_busy});
    chk({tag, "_done"}, {31'b0, done}, {31'b0, e_done});
    chk({tag, "_wcount"}, {27'b0, wcount}, e_wcount);
    chk({tag, "_start"}, {28'b0, start_addr}, e_start);
  endtask

  initial begin
    vecs[0]  = '{1, 3'd0, 32'h03020100};
    vecs[1]  = '{1, 3'd3, 32'h0F0E0D0C};
    vecs[2]  = '{1, 3'd4, 32'h83828180};
    vecs[3]  = '{1, 3'd7, 32'h8F8E8D8C};
    vecs[4]  = '{2, 3'd0, 32'h09060300};
    vecs[5]  = '{2, 3'd3, 32'h2D2A2724};
    vecs[6]  = '{2, 3'd5, 32'h95928F8C};
    vecs[7]  = '{3, 3'd0, 32'h13121110};
    vecs[8]  = '{3, 3'd2, 32'h0B0A1918};
    vecs[9]  = '{3, 3'd5, 32'h97969594};
    vecs[10] = '{3, 3'd7, 32'h8F8E8D8C};
    vecs[11] = '{4, 3'd0, 32'h03020100};
    vecs[12] = '{4, 3'd1, 32'h17161514};
    vecs[13] = '{4, 3'd4, 32'h83828180};
    vecs[14] = '{5, 3'd0, 32'h0D0C0B0A};
    vecs[15] = '{5, 3'd1, 32'h17100F0E};
    vecs[16] = '{5, 3'd4, 32'h8D8C8B8A};

    reset = 1'b1; arm = 1'b0; cfg_mode = 1'b0; cfg_post = '0; cfg_dec = '0;
    trig = 1'b0; wen = 1'b0; wdata = '0; ren = 1'b0; raddr = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk_status("reset", 1'b0, 1'b0, 0, 0);
    chk("reset_rdv", {31'b0, rdv}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // wen before any arm is ignored; first read exercises the latency model only
    sample(8'h55, 1'b0);
    chk("idle_wcount", {27'b0, wcount}, 32'd0);
    ren = 1'b1; raddr = 3'd0;
    exp_q.push_back('0); care_q.push_back(1'b0); nm_q.push_back("rdata_reset");
    tick();
    ren = 1'b0;
    repeat (3) tick();

    // scenario 1: one-shot, no decimation, trig ignored
    do_arm(1'b0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      sample(n, n == 5);
      if (n == 14) chk_status("s1_mid", 1'b1, 1'b0, 15, 0);
    end
    chk_status("s1_end", 1'b0, 1'b1, 16, 0);
    run_reads(1);

    // scenario 2: one-shot, keep 1 of 3
    do_arm(1'b0, 0, 2);
    for (int n = 0; n < 48; n++) begin
      sample(n, 1'b0);
      if (n == 44) chk_status("s2_mid", 1'b1, 1'b0, 15, 0);
    end
    chk_status("s2_end", 1'b0, 1'b1, 16, 0);
    run_reads(2);

    // scenario 3: circular, 5 post-trigger samples, trigger on sample 20
    do_arm(1'b1, 5, 0);
    for (int n = 0; n < 30; n++) begin
      sample(n, n == 20);
      if (n == 24) chk_status("s3_mid", 1'b1, 1'b0, 16, 0);
    end
    chk_status("s3_end", 1'b0, 1'b1, 16, 10);
    run_reads(3);

    // scenario 4: circular, zero post-trigger, trigger on sample 3
    do_arm(1'b1, 0, 0);
    chk_status("s4_arm", 1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 3; n++) sample(n, 1'b0);
    chk("s4_pre_done", {31'b0, done}, 32'd0);
    sample(3, 1'b1);
    chk("s4_trig_done", {31'b0, done}, 32'd1);
    sample(4, 1'b0);
    sample(5, 1'b0);
    chk_status("s4_end", 1'b0, 1'b1, 4, 0);
    run_reads(4);

    // scenario 5: re-arm during POST with coincident trig and wen
    do_arm(1'b1, 8, 0);
    for (int n = 0; n < 6; n++) sample(n, n == 2);
    arm = 1'b1; cfg_mode = 1'b1; cfg_post = 4'd2; cfg_dec = '0;
    trig = 1'b1; wen = 1'b1; wdata = {8'hAA, 8'h2A};
    tick();
    arm = 1'b0; trig = 1'b0; wen = 1'b0;
    chk_status("s5_rearm", 1'b1, 1'b0, 0, 0);
    for (int n = 10; n < 14; n++) sample(n, 1'b0);
    repeat (3) tick();
    chk_status("s5_fill", 1'b1, 1'b0, 4, 0);
    sample(14, 1'b1);
    sample(15, 1'b0);
    sample(16, 1'b0);
    sample(17, 1'b0);
    tick();
    chk_status("s5_end", 1'b0, 1'b1, 7, 0);
    run_reads(5);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
